// File: rtl/axis_width_conv_narrow_wide.sv
// Packs a narrow M-bit tnext-style stream into N-bit words (first beat in the MSBs).
// A tfirst beat arriving mid-word flushes the partial word zero-padded before it is consumed.
module axis_width_conv_narrow_wide #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         s_axis_tnext,
  input  logic [M-1:0] s_axis_tdata,
  input  logic         s_axis_tfirst,
  input  logic         s_axis_tvalid,
  input  logic         m_axis_tnext,
  output logic [N-1:0] m_axis_tdata,
  output logic         m_axis_tfirst,
  output logic         m_axis_tvalid
);

  localparam int K     = N / M;
  localparam int CNT_W = (K >= 2) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  if (M < 1 || (N % M) != 0 || K < 2) begin : g_param_check
    $error("axis_width_conv_narrow_wide: N must be K*M with K >= 2");
  end

  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_first_q, acc_first_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic             out_first_q, out_first_d;
  logic             out_valid_q, out_valid_d;

  logic         out_free;
  logic         is_flush;
  logic         is_complete;
  logic         is_fill;
  logic         load;
  logic [N-1:0] lane_bits;

  // Handshake: a beat moves on s_axis_tvalid && s_axis_tnext, a word on
  // m_axis_tvalid && m_axis_tnext; both tnext strobes act as FWFT read-enables.
  always_comb begin
    out_free    = !out_valid_q || m_axis_tnext;
    is_flush    = s_axis_tvalid && s_axis_tfirst && (cnt_q != '0);
    is_complete = s_axis_tvalid && !is_flush && (cnt_q == CNT_LAST);
    is_fill     = s_axis_tvalid && !is_flush && !is_complete;
    load        = (is_flush || is_complete) && out_free;
    // Incoming beat placed in lane cnt; unfilled accumulator lanes are always zero.
    lane_bits   = {s_axis_tdata, {(N-M){1'b0}}} >> (M * int'(cnt_q));

    s_axis_tnext = !rst && (is_fill || (is_complete && out_free));

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    acc_first_d = acc_first_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_valid_d = out_valid_q;

    if (is_fill) begin
      acc_d = acc_q | lane_bits;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == '0) begin
        acc_first_d = s_axis_tfirst;
      end
    end else if (load) begin
      acc_d       = '0;
      cnt_d       = '0;
      acc_first_d = 1'b0;
    end

    if (load) begin
      // A flushed word leaves the tfirst beat for the next cycle, so no lane merge.
      out_data_d  = is_complete ? (acc_q | lane_bits) : acc_q;
      out_first_d = acc_first_q;
      out_valid_d = 1'b1;
    end else if (m_axis_tnext) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      acc_first_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      acc_first_q <= acc_first_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tfirst = out_first_q;
  assign m_axis_tvalid = out_valid_q;

endmodule

// File: tb/tb_axis_width_conv_narrow_wide.sv
// Bench for the narrow-to-wide packer: directed scenarios plus a random
// word stream serialised the way the wide-to-narrow converter emits it.
module tb_axis_width_conv_narrow_wide;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       s_tnext, s_tfirst = 1'b0, s_tvalid = 1'b0;
  logic [3:0] s_tdata = '0;
  logic       m_tnext = 1'b1, m_tfirst, m_tvalid;
  logic [7:0] m_tdata;

  logic        w_s_tnext, w_s_tfirst = 1'b0, w_s_tvalid = 1'b0;
  logic [3:0]  w_s_tdata = '0;
  logic        w_m_tnext = 1'b1, w_m_tfirst, w_m_tvalid;
  logic [11:0] w_m_tdata;

  int errors = 0;
  int checks = 0;
  logic [8:0]  exp_q[$];
  logic [12:0] exp12_q[$];
  logic [8:0]  e8, hold_word;
  logic [12:0] e12;
  logic        hold = 1'b0;
  logic        rand_mode = 1'b0;

  axis_width_conv_narrow_wide #(.N(8), .M(4)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tnext(s_tnext), .s_axis_tdata(s_tdata), .s_axis_tfirst(s_tfirst), .s_axis_tvalid(s_tvalid),
    .m_axis_tnext(m_tnext), .m_axis_tdata(m_tdata), .m_axis_tfirst(m_tfirst), .m_axis_tvalid(m_tvalid)
  );

  axis_width_conv_narrow_wide #(.N(12), .M(4)) u_dut12 (
    .clk(clk), .rst(rst),
    .s_axis_tnext(w_s_tnext), .s_axis_tdata(w_s_tdata), .s_axis_tfirst(w_s_tfirst), .s_axis_tvalid(w_s_tvalid),
    .m_axis_tnext(w_m_tnext), .m_axis_tdata(w_m_tdata), .m_axis_tfirst(w_m_tfirst), .m_axis_tvalid(w_m_tvalid)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      m_tnext = ($urandom_range(0, 3) != 0);
    end
  end

  // scoreboard, N=8 instance: compare on each transfer, check hold stability
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold && m_tvalid) begin
        checks++;
        if ({m_tfirst, m_tdata} !== hold_word) begin
          errors++;
          $display("FAIL hold_stable: got %h required %h", {m_tfirst, m_tdata}, hold_word);
        end
      end
      if (m_tvalid && m_tnext) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h required none", {m_tfirst, m_tdata});
        end else begin
          e8 = exp_q.pop_front();
          if ({m_tfirst, m_tdata} !== e8) begin
            errors++;
            $display("FAIL word8: got first/data %h required %h", {m_tfirst, m_tdata}, e8);
          end
        end
      end
      hold      = m_tvalid && !m_tnext;
      hold_word = {m_tfirst, m_tdata};
    end
  end

  // scoreboard, N=12 instance
  always @(negedge clk) begin
    if (!rst && w_m_tvalid && w_m_tnext) begin
      checks++;
      if (exp12_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word12: got %h required none", {w_m_tfirst, w_m_tdata});
      end else begin
        e12 = exp12_q.pop_front();
        if ({w_m_tfirst, w_m_tdata} !== e12) begin
          errors++;
          $display("FAIL word12: got first/data %h required %h", {w_m_tfirst, w_m_tdata}, e12);
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic first, input logic [3:0] data, output int waits);
    logic taken;
    taken    = 1'b0;
    waits    = 0;
    s_tvalid = 1'b1;
    s_tfirst = first;
    s_tdata  = data;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (s_tnext) begin
        taken = 1'b1;
        break;
      end
      waits++;
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat %h not accepted in 1000 cycles", data);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tfirst = 1'b0;
  endtask

  task automatic send_beat12(input logic first, input logic [3:0] data);
    logic taken;
    taken      = 1'b0;
    w_s_tvalid = 1'b1;
    w_s_tfirst = first;
    w_s_tdata  = data;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (w_s_tnext) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL beat12_timeout: beat %h not accepted in 1000 cycles", data);
    end
    @(posedge clk);
    #1;
    w_s_tvalid = 1'b0;
    w_s_tfirst = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 1000 && (exp_q.size() != 0 || exp12_q.size() != 0); c++) idle(1);
    checks++;
    if (exp_q.size() != 0 || exp12_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d/%0d words outstanding required 0/0", name, exp_q.size(), exp12_q.size());
    end
    idle(2);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b1; s_tfirst = 1'b1; s_tdata = 4'h5;
    idle(3);
    checks++;
    if (s_tnext !== 1'b0) begin errors++; $display("FAIL reset_tnext: got %b required 0", s_tnext); end
    checks++;
    if ({m_tvalid, m_tfirst, m_tdata} !== 10'h000) begin
      errors++; $display("FAIL reset_out: got valid/first/data %b/%b/%h required 0/0/00", m_tvalid, m_tfirst, m_tdata);
    end
    checks++;
    if (w_m_tvalid !== 1'b0 || w_m_tdata !== 12'h000) begin
      errors++; $display("FAIL reset_out12: got %b/%h required 0/000", w_m_tvalid, w_m_tdata);
    end
    s_tvalid = 1'b0; s_tfirst = 1'b0;
    rst = 1'b0;
    idle(1);
    checks++;
    if (s_tnext !== 1'b0) begin errors++; $display("FAIL idle_tnext: got %b required 0", s_tnext); end
  endtask

  task automatic test_back_to_back();
    int w, wsum;
    m_tnext = 1'b1;
    exp_q.push_back(9'h1AB);
    exp_q.push_back(9'h0CD);
    send_beat(1'b1, 4'hA, w); wsum = w;
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b required 0", m_tvalid); end
    send_beat(1'b0, 4'hB, w); wsum += w;
    checks++;
    if (m_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_latency1: got valid %b required 1", m_tvalid); end
    send_beat(1'b0, 4'hC, w); wsum += w;
    send_beat(1'b0, 4'hD, w); wsum += w;
    checks++;
    if (m_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_latency2: got valid %b required 1", m_tvalid); end
    checks++;
    if (wsum != 0) begin errors++; $display("FAIL b2b_tnext: got %0d stall cycles required 0", wsum); end
    drain("b2b");
  endtask

  task automatic test_flush();
    int w;
    exp_q.push_back(9'h1A0);
    exp_q.push_back(9'h1BC);
    send_beat(1'b1, 4'hA, w);
    send_beat(1'b1, 4'hB, w);
    checks++;
    if (w != 1) begin errors++; $display("FAIL flush_stall: got %0d stall cycles required 1", w); end
    send_beat(1'b0, 4'hC, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL flush_after: got %0d stall cycles required 0", w); end
    drain("flush");
  endtask

  task automatic test_backpressure();
    int w3, w4;
    exp_q.push_back(9'h112);
    exp_q.push_back(9'h034);
    m_tnext = 1'b0;
    send_beat(1'b1, 4'h1, w3);
    send_beat(1'b0, 4'h2, w3);
    send_beat(1'b0, 4'h3, w3);
    checks++;
    if (w3 != 0) begin errors++; $display("FAIL bp_fill: got %0d stall cycles required 0", w3); end
    checks++;
    if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_held_valid: got %b required 1", m_tvalid); end
    fork
      send_beat(1'b0, 4'h4, w4);
      begin
        repeat (5) @(posedge clk);
        #1;
        m_tnext = 1'b1;
      end
    join
    checks++;
    if (w4 < 4) begin errors++; $display("FAIL bp_complete_stall: got %0d stall cycles required >=4", w4); end
    drain("bp");
  endtask

  task automatic test_reset_mid_word();
    int w;
    m_tnext = 1'b1;
    send_beat(1'b1, 4'h1, w);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", m_tvalid); end
    exp_q.push_back(9'h1EF);
    send_beat(1'b1, 4'hE, w);
    checks++;
    if (w != 0) begin errors++; $display("FAIL midreset_stale: got %0d stall cycles required 0", w); end
    send_beat(1'b0, 4'hF, w);
    drain("midreset");
  endtask

  task automatic test_wide12();
    w_m_tnext = 1'b1;
    exp12_q.push_back(13'h1120);
    exp12_q.push_back(13'h1345);
    send_beat12(1'b1, 4'h1);
    send_beat12(1'b0, 4'h2);
    send_beat12(1'b1, 4'h3);
    send_beat12(1'b0, 4'h4);
    send_beat12(1'b0, 4'h5);
    drain("wide12");
  endtask

  task automatic test_random_chain();
    int w;
    logic [7:0] word;
    logic       f;
    rand_mode = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      word = 8'($urandom_range(0, 255));
      f    = ($urandom_range(0, 10) == 0);
      exp_q.push_back({f, word});
      if ($urandom_range(0, 3) == 0) idle(1);
      send_beat(f, word[7:4], w);
      if ($urandom_range(0, 3) == 0) idle(1);
      send_beat(1'b0, word[3:0], w);
    end
    rand_mode = 1'b0;
    idle(2);
    m_tnext = 1'b1;
    drain("random");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_flush();
    test_backpressure();
    test_reset_mid_word();
    test_wide12();
    test_random_chain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_width_conv_narrow_wide.md
Name: axis_width_conv_narrow_wide

Overview:
- Packs a narrow M-bit stream into N-bit words, where N = K*M and K >= 2.
- Sits directly downstream of the wide-to-narrow converter, on the receive side of the narrow link.
- Uses the same tnext-style handshake: the consumer drives tnext as a read-enable on the producer's FWFT data.
- tfirst delimits packets. A packet always starts on a word boundary; partial words are zero-padded.

Parameters:
- N, 8, output word width; must be an integer multiple of M with N/M >= 2 (elaboration-time $error otherwise).
- M, 4, input beat width.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous reset, active-high.
- s_axis_tnext  output  1  accept strobe to upstream; a beat transfers on s_axis_tvalid && s_axis_tnext.
- s_axis_tdata  input  M  input beat.
- s_axis_tfirst  input  1  beat is the first of a packet.
- s_axis_tvalid  input  1  upstream data valid (FWFT).
- m_axis_tnext  input  1  downstream accept; a word transfers on m_axis_tvalid && m_axis_tnext; ignored when m_axis_tvalid=0.
- m_axis_tdata  output  N  packed word; the first beat occupies the MSBs [N-1 -: M].
- m_axis_tfirst  output  1  word starts a packet.
- m_axis_tvalid  output  1  output word valid.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State:
  - accumulator acc[N-1:0] and lane counter cnt (0..K-1);
  - acc_first, the tfirst of lane 0;
  - output register out_data / out_first / out_valid.
- out_free = !m_axis_tvalid || m_axis_tnext.
- s_axis_tnext is combinational. It is never high when s_axis_tvalid=0 or rst=1.
- Reset:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tfirst=0, cnt=0, acc=0, acc_first=0.
  - A partial word held at reset is discarded.
- Per cycle with s_axis_tvalid=1, evaluate in this priority:
  - FLUSH, when s_axis_tfirst=1 and cnt!=0:
    - If out_free: load out_data = received lanes with unfilled lanes zero, out_first = acc_first, out_valid = 1; set cnt=0 and acc=0.
    - s_axis_tnext=0; the tfirst beat is not consumed and is taken next cycle at cnt=0.
    - If !out_free: stall, with no state change.
  - COMPLETE, when cnt=K-1:
    - s_axis_tnext = out_free.
    - On accept: load out_data = {acc upper lanes, s_axis_tdata}, out_first = acc_first, out_valid = 1; set cnt=0 and acc=0.
  - FILL, otherwise:
    - s_axis_tnext=1, independent of the output side.
    - Write lane cnt (bits [N-1-cnt*M -: M]); cnt++.
    - If cnt=0, acc_first = s_axis_tfirst.
- Output register:
  - If not reloaded this cycle, out_valid clears on m_axis_tnext.
  - Load and drain in the same cycle is allowed: new data with valid held at 1, no bubble.
- Latency: the word is valid on the cycle after its K-th beat is accepted.
- Throughput: with downstream always ready, one word per K accepted beats, with no input stalls except the one-cycle FLUSH.
- A mid-packet beat at cnt=0 with tfirst=0 (upstream dropped tfirst) is packed normally with out_first=0.
- No end-of-stream flush: a partial word is held until the next tfirst or reset.
- m_axis_tdata and m_axis_tfirst are stable while m_axis_tvalid=1 && m_axis_tnext=0.

Test Plan:
1. N=8, M=4, m_axis_tnext=1. Beats (t,A),(-,B),(-,C),(-,D) back-to-back -> words (t,AB) and (-,CD). Each is valid one cycle after its 2nd/4th accept; s_axis_tnext stays high throughout.
2. N=8, M=4. Beats (t,A),(t,B),(-,C) -> (t,A0). s_axis_tnext is low for exactly one cycle on beat B, then (t,BC) follows.
3. Backpressure, N=8, M=4. Hold m_axis_tnext=0 for 5 cycles after the first word. Required: the next beat is accepted (FILL), then s_axis_tnext stays low on the completing beat until m_axis_tnext rises. Word 1 is held stable; no beat is lost or duplicated.
4. Reset mid-word. Accept (t,1), then pulse rst for 1 cycle -> m_axis_tvalid=0. Then (t,E),(-,F) -> single word (t,EF) with no stale lane.
5. N=12, M=4. Beats (t,1),(-,2),(t,3),(-,4),(-,5) -> (t,0x120) then (t,0x345).
6. Chained with the wide-to-narrow converter (N=8, M=4): 1024 random words, tfirst at 1/11 probability, random m_axis_tnext. Required: output equals input word-for-word, including tfirst; no deadlock within 1000 idle cycles.
